// File: rtl/alu_pkg.sv
// Shared ALU control codes, ALUOp/funct encodings and issue-unit FSM states.
// Imported by the decoder and the issue unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ILLEGAL = 2'b11;

  // {funct7[5], funct3}
  localparam logic [3:0] FUNCT_ADD = 4'b0000;
  localparam logic [3:0] FUNCT_SUB = 4'b1000;
  localparam logic [3:0] FUNCT_AND = 4'b0111;
  localparam logic [3:0] FUNCT_OR  = 4'b0110;
  localparam logic [3:0] FUNCT_SLT = 4'b0010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUOp/funct to ALU control decoder, shared with the single-cycle
// control path. Unknown combinations flag illegal and drive ctrl to ADD.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [3:0] funct,
  output logic [3:0] ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = ALU_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_LDST:   ctrl = ALU_ADD;
      ALUOP_BRANCH: ctrl = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
          default:   illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one decoded operation at a time to the combinational ALU and returns
// the captured result over a valid/ready response channel.
//
// state | meaning
// IDLE  | ready for a request; alu_* regs hold the last legal op
// EXEC  | ALU settling on the registered operands; result captured on exit
// RESP  | response valid and held until rsp_ready_i
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [1:0]        req_aluop_i,
  input  logic [3:0]        req_funct_i,
  input  logic [DATA_W-1:0] req_src1_i,
  input  logic [DATA_W-1:0] req_src2_i,
  input  logic [TAG_W-1:0]  req_tag_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [3:0]        alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              rsp_err_o
);

  state_t     state_q, state_d;
  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       accept;

  alu_op_decode u_decode (
    .aluop   (req_aluop_i),
    .funct   (req_funct_i),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign accept = req_valid_i && (state_q == ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Handshake outputs come from the state register only, so rsp_ready_i never
  // reaches req_ready_o combinationally.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = dec_illegal ? ST_RESP : ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      alu_src1_o   <= '0;
      alu_src2_o   <= '0;
      alu_ctrl_o   <= '0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_tag_o    <= '0;
      rsp_err_o    <= 1'b0;
    end else if (accept) begin
      rsp_tag_o <= req_tag_i;
      if (dec_illegal) begin
        // Illegal ops never reach the ALU, so its inputs keep the previous op.
        rsp_result_o <= '0;
        rsp_zero_o   <= 1'b0;
        rsp_err_o    <= 1'b1;
      end else begin
        alu_src1_o <= req_src1_i;
        alu_src2_o <= req_src2_i;
        alu_ctrl_o <= dec_ctrl;
      end
    end else if (state_q == ST_EXEC) begin
      rsp_result_o <= alu_result_i;
      rsp_zero_o   <= alu_zero_i;
      rsp_err_o    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed and randomized bench for alu_issue_unit with a behavioural ALU
// attached and an operation-level reference model.
module tb_alu_issue_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_aluop_i;
  logic [3:0]  req_funct_i;
  logic [63:0] req_src1_i, req_src2_i;
  logic [3:0]  req_tag_i;
  logic [63:0] alu_src1_o, alu_src2_o;
  logic [3:0]  alu_ctrl_o;
  logic [63:0] alu_result_i;
  logic        alu_zero_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_result_o;
  logic        rsp_zero_o;
  logic [3:0]  rsp_tag_o;
  logic        rsp_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0]  last_ctrl;
  logic [63:0] last_src1, last_src2;

  always #5 clk_i = ~clk_i;

  alu_issue_unit #(.DATA_W(64), .TAG_W(4)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_aluop_i  (req_aluop_i),
    .req_funct_i  (req_funct_i),
    .req_src1_i   (req_src1_i),
    .req_src2_i   (req_src2_i),
    .req_tag_i    (req_tag_i),
    .alu_src1_o   (alu_src1_o),
    .alu_src2_o   (alu_src2_o),
    .alu_ctrl_o   (alu_ctrl_o),
    .alu_result_i (alu_result_i),
    .alu_zero_i   (alu_zero_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_zero_o   (rsp_zero_o),
    .rsp_tag_o    (rsp_tag_o),
    .rsp_err_o    (rsp_err_o)
  );

  // Behavioural 64-bit ALU driven by the DUT's registered outputs
  always_comb begin
    alu_result_i = 64'h0;
    case (alu_ctrl_o)
      4'b0000: alu_result_i = alu_src1_o & alu_src2_o;
      4'b0001: alu_result_i = alu_src1_o | alu_src2_o;
      4'b0010: alu_result_i = alu_src1_o + alu_src2_o;
      4'b0110: alu_result_i = alu_src1_o - alu_src2_o;
      4'b0111: alu_result_i = {63'h0, $signed(alu_src1_o) < $signed(alu_src2_o)};
      default: alu_result_i = 64'h0;
    endcase
  end
  assign alu_zero_i = (alu_src1_o == alu_src2_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operation-level reference: what the request means, not how it is decoded
  task automatic ref_op(input logic [1:0] aluop, input logic [3:0] funct,
                        input logic [63:0] a, input logic [63:0] b,
                        output logic [3:0] ctrl, output bit illegal,
                        output logic [63:0] result, output logic zero);
    illegal = 0;
    ctrl    = 4'h0;
    result  = 64'h0;
    if (aluop == 2'd0) begin
      ctrl = 4'b0010; result = a + b;
    end else if (aluop == 2'd1) begin
      ctrl = 4'b0110; result = a - b;
    end else if (aluop == 2'd2 && funct == 4'b0000) begin
      ctrl = 4'b0010; result = a + b;
    end else if (aluop == 2'd2 && funct == 4'b1000) begin
      ctrl = 4'b0110; result = a - b;
    end else if (aluop == 2'd2 && funct == 4'b0111) begin
      ctrl = 4'b0000; result = a & b;
    end else if (aluop == 2'd2 && funct == 4'b0110) begin
      ctrl = 4'b0001; result = a | b;
    end else if (aluop == 2'd2 && funct == 4'b0010) begin
      ctrl = 4'b0111; result = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
    end else begin
      illegal = 1;
    end
    zero = illegal ? 1'b0 : (a == b);
  endtask

  // Called and returns just after a falling edge.
  task automatic do_op(input logic [1:0] aluop, input logic [3:0] funct,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] tag, input int bp, input bit junk);
    logic [3:0]  e_ctrl;
    bit          e_ill;
    logic [63:0] e_res, e_s1, e_s2;
    logic        e_zero;
    logic [3:0]  e_alu_ctrl;
    ref_op(aluop, funct, a, b, e_ctrl, e_ill, e_res, e_zero);
    e_alu_ctrl = e_ill ? last_ctrl : e_ctrl;
    e_s1       = e_ill ? last_src1 : a;
    e_s2       = e_ill ? last_src2 : b;
    check("req_ready_idle", {63'h0, req_ready_o}, 64'd1);
    req_valid_i = 1'b1; req_aluop_i = aluop; req_funct_i = funct;
    req_src1_i = a; req_src2_i = b; req_tag_i = tag;
    @(posedge clk_i); @(negedge clk_i);
    req_valid_i = 1'b0;
    if (!e_ill) begin
      check("exec_rsp_valid", {63'h0, rsp_valid_o}, 64'd0);
      check("exec_req_ready", {63'h0, req_ready_o}, 64'd0);
      check("alu_ctrl", {60'h0, alu_ctrl_o}, {60'h0, e_alu_ctrl});
      @(posedge clk_i); @(negedge clk_i);
    end
    check("alu_ctrl_hold", {60'h0, alu_ctrl_o}, {60'h0, e_alu_ctrl});
    check("alu_src1", alu_src1_o, e_s1);
    check("alu_src2", alu_src2_o, e_s2);
    check("rsp_valid", {63'h0, rsp_valid_o}, 64'd1);
    check("rsp_result", rsp_result_o, e_res);
    check("rsp_zero", {63'h0, rsp_zero_o}, {63'h0, e_zero});
    check("rsp_tag", {60'h0, rsp_tag_o}, {60'h0, tag});
    check("rsp_err", {63'h0, rsp_err_o}, {63'h0, e_ill});
    for (int i = 0; i < bp; i++) begin
      if (junk) begin
        req_valid_i = 1'b1; req_aluop_i = 2'd0;
        req_src1_i = {$urandom, $urandom}; req_src2_i = {$urandom, $urandom};
        req_tag_i = 4'(~tag);
      end
      @(posedge clk_i); @(negedge clk_i);
      check("bp_rsp_valid", {63'h0, rsp_valid_o}, 64'd1);
      check("bp_req_ready", {63'h0, req_ready_o}, 64'd0);
      check("bp_result", rsp_result_o, e_res);
      check("bp_tag", {60'h0, rsp_tag_o}, {60'h0, tag});
      check("bp_alu_src1", alu_src1_o, e_s1);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("post_rsp_valid", {63'h0, rsp_valid_o}, 64'd0);
    check("post_req_ready", {63'h0, req_ready_o}, 64'd1);
    last_ctrl = e_alu_ctrl; last_src1 = e_s1; last_src2 = e_s2;
  endtask

  initial begin
    logic [3:0]  legal_funct [5];
    logic [63:0] ra, rb;
    logic [3:0]  rf;
    legal_funct[0] = 4'b0000; legal_funct[1] = 4'b1000; legal_funct[2] = 4'b0111;
    legal_funct[3] = 4'b0110; legal_funct[4] = 4'b0010;
    rst_n_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
    req_aluop_i = 2'd0; req_funct_i = 4'd0; req_src1_i = '0; req_src2_i = '0; req_tag_i = '0;
    last_ctrl = 4'h0; last_src1 = '0; last_src2 = '0;
    repeat (2) @(negedge clk_i);
    check("rst_req_ready", {63'h0, req_ready_o}, 64'd1);
    check("rst_rsp_valid", {63'h0, rsp_valid_o}, 64'd0);
    check("rst_alu_ctrl", {60'h0, alu_ctrl_o}, 64'd0);
    check("rst_alu_src1", alu_src1_o, 64'd0);
    check("rst_rsp_result", rsp_result_o, 64'd0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    do_op(2'b00, 4'h0, 64'd5, 64'd7, 4'd3, 0, 0);
    do_op(2'b01, 4'h0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 4'd4, 1, 0);
    do_op(2'b10, 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd5, 0, 0);
    do_op(2'b10, 4'b0010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 4'd6, 0, 0);
    do_op(2'b11, 4'h0, 64'd9, 64'd9, 4'd7, 0, 0);
    do_op(2'b10, 4'b0101, 64'd1, 64'd2, 4'd8, 2, 0);
    do_op(2'b10, 4'b0111, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_FF00, 4'd9, 5, 1);
    do_op(2'b10, 4'b0110, 64'h8000_0000_0000_0000, 64'h1, 4'd10, 0, 0);

    // Asynchronous reset while an op is in EXEC
    req_valid_i = 1'b1; req_aluop_i = 2'b00; req_funct_i = 4'h0;
    req_src1_i = 64'd100; req_src2_i = 64'd23; req_tag_i = 4'd11;
    @(posedge clk_i);
    #2;
    req_valid_i = 1'b0;
    rst_n_i = 1'b0;
    #1;
    check("arst_rsp_valid", {63'h0, rsp_valid_o}, 64'd0);
    check("arst_alu_ctrl", {60'h0, alu_ctrl_o}, 64'd0);
    check("arst_alu_src1", alu_src1_o, 64'd0);
    check("arst_alu_src2", alu_src2_o, 64'd0);
    check("arst_rsp_tag", {60'h0, rsp_tag_o}, 64'd0);
    check("arst_req_ready", {63'h0, req_ready_o}, 64'd1);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    last_ctrl = 4'h0; last_src1 = '0; last_src2 = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("arst_no_rsp", {63'h0, rsp_valid_o}, 64'd0);
    end
    do_op(2'b00, 4'h0, 64'd40, 64'd2, 4'd12, 0, 0);

    for (int n = 0; n < 60; n++) begin
      ra = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = 64'($urandom_range(0, 7));
        default: rb = {$urandom, $urandom};
      endcase
      rf = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                       : legal_funct[$urandom_range(0, 4)];
      do_op(2'($urandom_range(0, 3)), rf, ra, rb, 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
